vram_write_scheduler: RTL and testbench

//  Queues CPU (Avalon slave) writes bound for the video memories and releases them to addr_decode only

---
 rtl/vram_write_scheduler.sv | 108 ++++++++++
 tb/tb_vram_write_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_scheduler.sv
// Write queue between the Avalon slave and addr_decode. CPU writes are buffered
// and released one per cycle only inside blanking windows, after a settle guard.
module vram_write_scheduler #(
  parameter int DEPTH        = 16,
  parameter int GUARD_CYCLES = 4,
  parameter int HBLANK_EN    = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     chipselect,
  input  logic                     write,
  input  logic [11:0]              address,
  input  logic [31:0]              writedata,
  output logic                     waitrequest,
  input  logic                     vblank,
  input  logic                     hblank,
  input  logic                     render_req,
  output logic [11:0]              dec_addr,
  output logic [31:0]              dec_write_data,
  output logic                     dec_chip_select,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GLOAD = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_gcnt, w_gcnt_nxt;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic [43:0]   r_mem [DEPTH];
  logic          w_window, w_full, w_empty, w_push, w_pop;

  assign w_window    = vblank | (hblank & (HBLANK_EN != 0));
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_push      = chipselect & write & ~w_full;
  assign w_pop       = (r_state == S_DRAIN) & w_window & ~render_req & ~w_empty;
  assign waitrequest = w_full;
  assign level       = r_level;
  assign idle        = w_empty & (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_gcnt_nxt  = r_gcnt;
    case (r_state)
      S_IDLE:
        if (w_window && !w_empty) begin
          if (GUARD_CYCLES == 0) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_GUARD;
            w_gcnt_nxt  = GLOAD;
          end
        end
      S_GUARD:
        if (!w_window)           w_state_nxt = S_IDLE;
        else if (r_gcnt == '0)   w_state_nxt = S_DRAIN;
        else                     w_gcnt_nxt  = r_gcnt - GW'(1);
      S_DRAIN:
        if (w_empty || !w_window) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gcnt  <= w_gcnt_nxt;
    end
  end

  // Storage needs no reset: an empty level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {address, writedata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_level         <= '0;
      dec_addr        <= '0;
      dec_write_data  <= '0;
      dec_chip_select <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        r_rptr                     <= r_rptr + PW'(1);
        {dec_addr, dec_write_data} <= r_mem[r_rptr];
      end
      dec_chip_select <= w_pop;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: tb/tb_vram_write_scheduler.sv
// Drives two scheduler configurations with shared stimulus and checks every
// output each cycle against a queue-based behavioural model.
module tb_vram_write_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic chipselect = 1'b0, write = 1'b0, vblank = 1'b0, hblank = 1'b0, render_req = 1'b0;
  logic [11:0] address = '0;
  logic [31:0] writedata = '0;

  logic wait0, cs0, idle0, wait1, cs1, idle1;
  logic [11:0] a0, a1;
  logic [31:0] d0, d1;
  logic [4:0]  lvl0;
  logic [2:0]  lvl1;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  vram_write_scheduler u0 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .waitrequest(wait0), .vblank(vblank), .hblank(hblank),
    .render_req(render_req), .dec_addr(a0), .dec_write_data(d0), .dec_chip_select(cs0),
    .level(lvl0), .idle(idle0));

  vram_write_scheduler #(.DEPTH(4), .GUARD_CYCLES(0), .HBLANK_EN(0)) u1 (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .waitrequest(wait1), .vblank(vblank), .hblank(hblank),
    .render_req(render_req), .dec_addr(a1), .dec_write_data(d1), .dec_chip_select(cs1),
    .level(lvl1), .idle(idle1));

  // reference model: per configuration a circular list of pending writes plus a mode
  int DEP[2] = '{16, 4};
  int GRD[2] = '{4, 0};
  bit HB[2]  = '{1'b1, 1'b0};
  logic [43:0] m_buf [2][64];
  int   m_head[2], m_cnt[2], m_mode[2], m_g[2];  // mode 0 idle, 1 guard, 2 drain
  bit   m_cs[2];
  logic [11:0] m_a[2];
  logic [31:0] m_d[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_head[k] = 0; m_cnt[k] = 0; m_mode[k] = 0; m_g[k] = 0;
      m_cs[k] = 1'b0; m_a[k] = '0; m_d[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit win, full, empty, push, pop;
      win   = vblank | (hblank & HB[k]);
      full  = (m_cnt[k] == DEP[k]);
      empty = (m_cnt[k] == 0);
      push  = chipselect & write & !full;
      pop   = (m_mode[k] == 2) && win && !render_req && !empty;
      case (m_mode[k])
        0: if (win && !empty) begin
             if (GRD[k] == 0) m_mode[k] = 2;
             else begin m_mode[k] = 1; m_g[k] = GRD[k] - 1; end
           end
        1: if (!win) m_mode[k] = 0;
           else if (m_g[k] == 0) m_mode[k] = 2;
           else m_g[k]--;
        default: if (empty || !win) m_mode[k] = 0;
      endcase
      m_cs[k] = pop;
      if (pop) begin
        {m_a[k], m_d[k]} = m_buf[k][m_head[k] % 64];
        m_head[k]++; m_cnt[k]--;
      end
      if (push) begin
        m_buf[k][(m_head[k] + m_cnt[k]) % 64] = {address, writedata};
        m_cnt[k]++;
      end
    end
  endtask

  task automatic cmp_all();
    chk("cs0", cs0, m_cs[0]);   chk("addr0", a0, m_a[0]);  chk("data0", d0, m_d[0]);
    chk("lvl0", lvl0, m_cnt[0]); chk("wait0", wait0, m_cnt[0] == DEP[0]);
    chk("idle0", idle0, m_cnt[0] == 0 && m_mode[0] == 0);
    chk("cs1", cs1, m_cs[1]);   chk("addr1", a1, m_a[1]);  chk("data1", d1, m_d[1]);
    chk("lvl1", lvl1, m_cnt[1]); chk("wait1", wait1, m_cnt[1] == DEP[1]);
    chk("idle1", idle1, m_cnt[1] == 0 && m_mode[1] == 0);
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic cycs(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // holds the write until configuration 0 accepts it
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int n = 0;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    while (m_cnt[0] == DEP[0] && n < 300) begin cyc(); n++; end
    chk("wr_timeout", n < 300, 1'b1);
    cyc();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic reset_check();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_cs0", cs0, 1'b0);  chk("rst_lvl0", lvl0, 0); chk("rst_idle0", idle0, 1'b1);
    chk("rst_wait0", wait0, 1'b0); chk("rst_addr0", a0, 0); chk("rst_data0", d0, 0);
    chk("rst_cs1", cs1, 1'b0);  chk("rst_lvl1", lvl1, 0); chk("rst_idle1", idle1, 1'b1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int f0, f1;
    @(negedge clk);
    reset_check();

    // ordering + guard latency
    wr(12'h001, 32'hA); wr(12'h201, 32'hB); wr(12'hC03, 32'hC); wr(12'hE04, 32'hD);
    vblank = 1'b1;
    f0 = 0; f1 = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (cs0 && f0 == 0) f0 = i;
      if (cs1 && f1 == 0) f1 = i;
    end
    chk("lat0", f0, 6);
    chk("lat1", f1, 2);
    vblank = 1'b0; cyc();

    // full queue and held 17th write
    for (int i = 0; i < 16; i++) wr(12'(12'h100 + i), 32'(32'h5000 + i));
    chk("full_lvl0", lvl0, 16);
    chk("full_wait0", wait0, 1'b1);
    chipselect = 1'b1; write = 1'b1; address = 12'h1FF; writedata = 32'h5FFF;
    cycs(3);
    chk("held_lvl0", lvl0, 16);
    vblank = 1'b1;
    wr(12'h1FF, 32'h5FFF);
    cycs(40);
    vblank = 1'b0; cyc();

    // render_req stall in drain
    for (int i = 0; i < 6; i++) wr(12'(12'h300 + i), 32'($urandom));
    vblank = 1'b1; cycs(7);
    render_req = 1'b1; cycs(3);
    render_req = 1'b0; cycs(12);
    vblank = 1'b0; cyc();

    // hblank window closes mid-drain
    for (int i = 0; i < 8; i++) wr(12'(12'h400 + i), 32'($urandom));
    hblank = 1'b1; cycs(7);
    chk("hb_part0", lvl0, 6);
    chk("hb_none1", lvl1, 4);
    hblank = 1'b0; cycs(5);
    hblank = 1'b1; cycs(15);
    hblank = 1'b0; cyc();
    vblank = 1'b1; cycs(10);

    // write every cycle during drain
    chipselect = 1'b1; write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      address = 12'($urandom); writedata = $urandom; cyc();
    end
    chipselect = 1'b0; write = 1'b0; cycs(30);
    vblank = 1'b0; cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      write      = ($urandom_range(0, 2) != 0);
      address    = 12'($urandom);
      writedata  = $urandom;
      render_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      if ($urandom_range(0, 5) == 0)  hblank = ~hblank;
      cyc();
    end
    chipselect = 1'b0; write = 1'b0; render_req = 1'b0; vblank = 1'b0; hblank = 1'b0;
    cyc();

    // reset while draining with entries still queued
    for (int i = 0; i < 7; i++) wr(12'(12'h700 + i), 32'($urandom));
    vblank = 1'b1; cycs(7);
    chk("pre_rst_cs0", cs0, 1'b1);
    reset_check();
    vblank = 1'b0; cycs(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
